// File: rtl/instr_decoder_if.sv
// Decode-stage bus: instruction handshake in, decoded control word out.
// The decoder uses the slave modport; the upstream/downstream driver uses master.
interface instr_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [31:0] out_imm;
  logic [25:0] out_jaddr;
  logic        out_rf_we;
  logic        out_sel_alu_b;
  logic        out_dmem_we;
  logic [1:0]  out_sel_wa;
  logic [1:0]  out_sel_result;
  logic [1:0]  out_sel_pc;
  logic [3:0]  out_alu_ctrl;
  logic        out_branch;
  logic        out_illegal;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct,
           out_imm, out_jaddr, out_rf_we, out_sel_alu_b, out_dmem_we, out_sel_wa,
           out_sel_result, out_sel_pc, out_alu_ctrl, out_branch, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct,
           out_imm, out_jaddr, out_rf_we, out_sel_alu_b, out_dmem_we, out_sel_wa,
           out_sel_result, out_sel_pc, out_alu_ctrl, out_branch, out_illegal
  );
endinterface

// File: rtl/instr_decoder.sv
// MIPS decode stage with a 2-entry output buffer. Define DECODER_TRAP_EN to stall
// intake on illegal words until trap_clr_i.
module instr_decoder (
  input  logic              clk,
  input  logic              rst_n,
  instr_decoder_if.slave    bus,
  input  logic              trap_clr_i,
  output logic              trap_o
);

  typedef struct packed {
    logic       rf_we;
    logic [1:0] sel_wa;
    logic       sel_alu_b;
    logic       dmem_we;
    logic [1:0] sel_result;
    logic [1:0] sel_pc;
    logic [3:0] alu_ctrl;
    logic       branch;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] instr;
    ctrl_t       ctrl;
  } entry_t;

  typedef enum logic [0:0] {StRun, StTrap} state_e;

  state_e      state_q, state_d;
  entry_t      buf_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  cnt_q, cnt_d;
  ctrl_t       dec;
  entry_t      head;
  logic        push, pop;

  always_comb begin
    dec = '0;
    unique case (bus.in_instr[31:26])
      6'h23: begin dec.rf_we = 1'b1; dec.sel_alu_b = 1'b1; end
      6'h2B: begin dec.sel_alu_b = 1'b1; dec.dmem_we = 1'b1; dec.sel_result = 2'b01; end
      6'h08: begin dec.rf_we = 1'b1; dec.sel_alu_b = 1'b1; dec.sel_result = 2'b01; end
      6'h02: begin dec.sel_result = 2'b01; dec.sel_pc = 2'b10; end
      6'h03: begin
        dec.rf_we = 1'b1; dec.sel_wa = 2'b10; dec.sel_result = 2'b10; dec.sel_pc = 2'b10;
      end
      6'h04: begin dec.sel_result = 2'b01; dec.alu_ctrl = 4'd1; dec.branch = 1'b1; end
      6'h00: begin
        dec.rf_we = 1'b1; dec.sel_wa = 2'b01; dec.sel_result = 2'b01;
        unique case (bus.in_instr[5:0])
          6'h20: dec.alu_ctrl = 4'd2;
          6'h22: dec.alu_ctrl = 4'd3;
          6'h24: dec.alu_ctrl = 4'd4;
          6'h25: dec.alu_ctrl = 4'd5;
          6'h2A: dec.alu_ctrl = 4'd6;
          6'h19: dec.alu_ctrl = 4'd7;
          6'h1B: dec.alu_ctrl = 4'd8;
          6'h10: dec.alu_ctrl = 4'd9;
          6'h12: dec.alu_ctrl = 4'd10;
          6'h08: begin dec.rf_we = 1'b0; dec.sel_pc = 2'b11; dec.alu_ctrl = 4'd11; end
          default: begin dec = '0; dec.illegal = 1'b1; end
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign bus.in_ready = (cnt_q != 2'd2) && (state_q == StRun);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = bus.out_ready && (cnt_q != 2'd0);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
`ifdef DECODER_TRAP_EN
    unique case (state_q)
      StRun:   if (push && dec.illegal) state_d = StTrap;
      StTrap:  if (trap_clr_i) state_d = StRun;
      default: state_d = StRun;
    endcase
`endif
  end

`ifndef DECODER_TRAP_EN
  logic unused_trap_clr;
  assign unused_trap_clr = trap_clr_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      cnt_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push) begin
        buf_q[wr_ptr_q] <= '{instr: bus.in_instr, ctrl: dec};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Empty buffer shows an all-zero word so stale entries never leak out.
  assign head = (cnt_q != 2'd0) ? buf_q[rd_ptr_q] : '0;

  assign trap_o             = (state_q == StTrap);
  assign bus.out_valid      = (cnt_q != 2'd0);
  assign bus.out_opcode     = head.instr[31:26];
  assign bus.out_rs         = head.instr[25:21];
  assign bus.out_rt         = head.instr[20:16];
  assign bus.out_rd         = head.instr[15:11];
  assign bus.out_shamt      = head.instr[10:6];
  assign bus.out_funct      = head.instr[5:0];
  assign bus.out_imm        = {{16{head.instr[15]}}, head.instr[15:0]};
  assign bus.out_jaddr      = head.instr[25:0];
  assign bus.out_rf_we      = head.ctrl.rf_we;
  assign bus.out_sel_wa     = head.ctrl.sel_wa;
  assign bus.out_sel_alu_b  = head.ctrl.sel_alu_b;
  assign bus.out_dmem_we    = head.ctrl.dmem_we;
  assign bus.out_sel_result = head.ctrl.sel_result;
  assign bus.out_sel_pc     = head.ctrl.sel_pc;
  assign bus.out_alu_ctrl   = head.ctrl.alu_ctrl;
  assign bus.out_branch     = head.ctrl.branch;
  assign bus.out_illegal    = head.ctrl.illegal;

endmodule

// File: tb/tb_instr_decoder.sv
// Scoreboard bench for instr_decoder; expectations follow DECODER_TRAP_EN when defined.
module tb_instr_decoder;

  typedef struct packed {
    logic [31:0] instr;
    logic        rf_we;
    logic [1:0]  sel_wa;
    logic        alu_b;
    logic        dmem_we;
    logic [1:0]  sel_result;
    logic [1:0]  sel_pc;
    logic [3:0]  alu_ctrl;
    logic        branch;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic trap_clr = 1'b0;
  logic trap;
  int   checks = 0;
  int   failures = 0;
  bit   trap_m = 1'b0;
  exp_t q[$];

  instr_decoder_if bus ();

  instr_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .trap_clr_i (trap_clr),
    .trap_o     (trap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    e = '0;
    e.instr = w;
    case (w[31:26])
      6'h23: begin e.rf_we = 1; e.alu_b = 1; end
      6'h2B: begin e.alu_b = 1; e.dmem_we = 1; e.sel_result = 2'b01; end
      6'h08: begin e.rf_we = 1; e.alu_b = 1; e.sel_result = 2'b01; end
      6'h02: begin e.sel_result = 2'b01; e.sel_pc = 2'b10; end
      6'h03: begin e.rf_we = 1; e.sel_wa = 2'b10; e.sel_result = 2'b10; e.sel_pc = 2'b10; end
      6'h04: begin e.sel_result = 2'b01; e.alu_ctrl = 1; e.branch = 1; end
      6'h00: begin
        e.rf_we = 1; e.sel_wa = 2'b01; e.sel_result = 2'b01;
        case (w[5:0])
          6'h20: e.alu_ctrl = 2;
          6'h22: e.alu_ctrl = 3;
          6'h24: e.alu_ctrl = 4;
          6'h25: e.alu_ctrl = 5;
          6'h2A: e.alu_ctrl = 6;
          6'h19: e.alu_ctrl = 7;
          6'h1B: e.alu_ctrl = 8;
          6'h10: e.alu_ctrl = 9;
          6'h12: e.alu_ctrl = 10;
          6'h08: begin e.rf_we = 0; e.sel_pc = 2'b11; e.alu_ctrl = 11; end
          default: begin
            e = '0; e.instr = w; e.illegal = 1;
          end
        endcase
      end
      default: e.illegal = 1;
    endcase
    return e;
  endfunction

  // Checks head/handshake each cycle, then advances the model for the coming edge.
  always @(negedge clk) begin
    if (rst_n) begin
      bit   nxt_trap;
      bit   do_pop;
      exp_t e;
      check_eq("out_valid", bus.out_valid, q.size() > 0);
      check_eq("in_ready", bus.in_ready, (q.size() < 2) && !trap_m);
      check_eq("trap", trap, trap_m);
      if (q.size() > 0) begin
        e = q[0];
        check_eq("fields", {bus.out_opcode, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_shamt,
                            bus.out_funct}, e.instr);
        check_eq("imm", bus.out_imm, {{16{e.instr[15]}}, e.instr[15:0]});
        check_eq("jaddr", bus.out_jaddr, e.instr[25:0]);
        check_eq("ctrl", {bus.out_rf_we, bus.out_sel_wa, bus.out_sel_alu_b, bus.out_dmem_we,
                          bus.out_sel_result, bus.out_sel_pc, bus.out_alu_ctrl, bus.out_branch,
                          bus.out_illegal},
                 {e.rf_we, e.sel_wa, e.alu_b, e.dmem_we, e.sel_result, e.sel_pc, e.alu_ctrl,
                  e.branch, e.illegal});
      end else begin
        check_eq("idle_zero", {bus.out_imm, bus.out_jaddr, bus.out_opcode, bus.out_alu_ctrl,
                               bus.out_rf_we, bus.out_sel_pc, bus.out_illegal}, 64'd0);
      end
      nxt_trap = trap_m;
      do_pop   = (q.size() > 0) && bus.out_ready;
      if (bus.in_valid && (q.size() < 2) && !trap_m) begin
        e = model(bus.in_instr);
`ifdef DECODER_TRAP_EN
        if (e.illegal) nxt_trap = 1'b1;
`endif
        if (do_pop) void'(q.pop_front());
        q.push_back(e);
      end else if (do_pop) begin
        void'(q.pop_front());
      end
`ifdef DECODER_TRAP_EN
      if (trap_m && trap_clr) nxt_trap = 1'b0;
`endif
      trap_m = nxt_trap;
    end
  end

  task automatic send(input logic [31:0] w);
    int n;
    bit done;
    n = 0;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = w;
    while (!done) begin
      @(negedge clk);
      done = bus.in_ready;
      if (!done) begin
        n++;
        if (n > 50) begin
          check_eq("send_timeout", 1, 0);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  logic [31:0] pool [16] = '{
    32'h8C220004, 32'hAC220008, 32'h2001FFFC, 32'h08000010, 32'h0C000020, 32'h10220003,
    32'h00A63820, 32'h00A63822, 32'h00A63824, 32'h00A63825, 32'h00A6382A, 32'h00A60019,
    32'h00A6001B, 32'h00003810, 32'h03E00008, 32'hFC000000
  };

  initial begin
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h8C220004;
    bus.out_ready = 1'b1;
    #12;
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_trap", trap, 0);
    check_eq("rst_zero", {bus.out_imm, bus.out_opcode, bus.out_rf_we, bus.out_sel_alu_b}, 0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    send(32'h8C220004);
    check_eq("lw_rs", bus.out_rs, 5'd1);
    check_eq("lw_rt", bus.out_rt, 5'd2);
    check_eq("lw_imm", bus.out_imm, 32'h4);
    check_eq("lw_ctrl", {bus.out_rf_we, bus.out_sel_alu_b, bus.out_sel_result}, 4'b1100);

    send(32'h00A63820);
    check_eq("add_alu", bus.out_alu_ctrl, 4'd2);
    send(32'h03E00008);
    check_eq("jr_pc", {bus.out_rf_we, bus.out_sel_pc, bus.out_alu_ctrl}, 7'b0_11_1011);
    send(32'h2001FFFC);
    check_eq("addi_imm", bus.out_imm, 32'hFFFFFFFC);
    for (int i = 0; i < 15; i++) send(pool[i]);
    send(32'h00A6003F);
    trap_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1 trap_clr = 1'b0;

    bus.out_ready = 1'b0;
    fork
      begin
        send(32'h8C220004);
        send(32'h00A63822);
        send(32'h10220003);
      end
      begin
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join

    send(32'hFC000000);
    check_eq("illegal_flag", bus.out_illegal, 1);
    check_eq("illegal_nop", {bus.out_rf_we, bus.out_sel_pc, bus.out_alu_ctrl}, 0);
`ifdef DECODER_TRAP_EN
    repeat (3) @(posedge clk);
    #1;
    check_eq("trap_hold", trap, 1);
    check_eq("trap_ready", bus.in_ready, 0);
    trap_clr = 1'b1;
    @(posedge clk);
    #1 trap_clr = 1'b0;
    check_eq("trap_clear", trap, 0);
`endif
    send(32'h8C220004);

    for (int i = 0; i < 300; i++) begin
      bus.in_valid  = $urandom_range(0, 1) == 1;
      bus.in_instr  = pool[$urandom_range(0, 15)];
      bus.out_ready = $urandom_range(0, 3) != 0;
      trap_clr      = $urandom_range(0, 7) == 0;
      @(posedge clk);
      #1;
    end

    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00A63825;
    trap_clr      = 1'b1;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("flush_valid", bus.out_valid, 0);
    check_eq("flush_ready", bus.in_ready, 1);
    check_eq("flush_trap", trap, 0);
    q.delete();
    trap_m = 1'b0;
    bus.in_valid  = 1'b0;
    trap_clr      = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(32'h0C000020);
    repeat (4) @(posedge clk);
    #1;
    check_eq("drained", bus.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
